cond_unit: RTL and testbench

Condition unit that sits downstream of the ALU.
- Holds the architectural N/Z/C/V flag register, loaded from the ALU's 4-bit `ALUFlag` output `{Negative, Zero, CarryOut, Overflow}`.
- Evaluates each instruction's 4-bit condition field against the stored flags.
- Gates the decoder's PC, register and memory write enables, so a failing conditional instruction has no architectural side effects.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/cond_check.sv | 44 ++++
 rtl/cond_unit.sv | 98 +++++++++
 tb/tb_cond_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-code encodings, flag bit positions and the
// packed flag type used by the ALU and the condition unit.
package cpu_pkg;

    localparam int unsigned FLAG_WIDTH = 4;
    localparam int unsigned COND_WIDTH = 4;

    // Bit positions inside a packed {N,Z,C,V} flag word
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef logic [FLAG_WIDTH-1:0] flags_t;

    // Instruction condition field encodings, bits [31:28]
    localparam logic [COND_WIDTH-1:0] COND_EQ = 4'h0;
    localparam logic [COND_WIDTH-1:0] COND_NE = 4'h1;
    localparam logic [COND_WIDTH-1:0] COND_CS = 4'h2;
    localparam logic [COND_WIDTH-1:0] COND_CC = 4'h3;
    localparam logic [COND_WIDTH-1:0] COND_MI = 4'h4;
    localparam logic [COND_WIDTH-1:0] COND_PL = 4'h5;
    localparam logic [COND_WIDTH-1:0] COND_VS = 4'h6;
    localparam logic [COND_WIDTH-1:0] COND_VC = 4'h7;
    localparam logic [COND_WIDTH-1:0] COND_HI = 4'h8;
    localparam logic [COND_WIDTH-1:0] COND_LS = 4'h9;
    localparam logic [COND_WIDTH-1:0] COND_GE = 4'hA;
    localparam logic [COND_WIDTH-1:0] COND_LT = 4'hB;
    localparam logic [COND_WIDTH-1:0] COND_GT = 4'hC;
    localparam logic [COND_WIDTH-1:0] COND_LE = 4'hD;
    localparam logic [COND_WIDTH-1:0] COND_AL = 4'hE;
    localparam logic [COND_WIDTH-1:0] COND_NV = 4'hF;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: (Cond, Flags) -> CondEx.
// Ports:
//   Cond   in  4  instruction condition field
//   Flags  in  4  flag word {N,Z,C,V}
//   CondEx out 1  condition passed
module cond_check
    import cpu_pkg::*;
(
    input  logic [COND_WIDTH-1:0] Cond,
    input  flags_t                Flags,
    output logic                  CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    // Condition decode; the reserved NV encoding never passes
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = ~z & c;
            COND_LS: CondEx = z | ~c;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition unit: holds the N/Z/C/V flag register, evaluates the condition
// field against the stored flags and gates the decoder's write enables.
// Optional macro COND_UNIT_SHADOW_EN adds a shadow flag register with
// SaveFlags/RestoreFlags for exception entry and return.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   Cond, ALUFlag, FlagW    condition field, ALU flags, flag-write request
//   PCS, RegW, MemW         ungated decoder write requests
//   Stall                   freezes all register updates
//   SaveFlags, RestoreFlags shadow control (macro build only)
//   CondEx, PCSrc, RegWrite, MemWrite  combinational pass/gated enables
//   Flags                   current flag register
module cond_unit
    import cpu_pkg::*;
#(
    parameter flags_t RESET_FLAGS = 4'b0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [COND_WIDTH-1:0] Cond,
    input  flags_t                ALUFlag,
    input  logic [1:0]            FlagW,
    input  logic                  PCS,
    input  logic                  RegW,
    input  logic                  MemW,
    input  logic                  Stall,
`ifdef COND_UNIT_SHADOW_EN
    input  logic                  SaveFlags,
    input  logic                  RestoreFlags,
`endif
    output logic                  CondEx,
    output logic                  PCSrc,
    output logic                  RegWrite,
    output logic                  MemWrite,
    output flags_t                Flags
);

    logic [1:0] flag_write;
    flags_t     flags_next;

    // Evaluated on the stored flags only, so ALUFlag never reaches an output
    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (Flags),
        .CondEx (CondEx)
    );

    assign PCSrc    = PCS  & CondEx;
    assign RegWrite = RegW & CondEx;
    assign MemWrite = MemW & CondEx;

    // A failing instruction must not touch the flags
    assign flag_write = FlagW & {2{CondEx}};

`ifdef COND_UNIT_SHADOW_EN
    flags_t shadow;
    flags_t shadow_next;
`endif

    // Next flag value: N,Z and C,V halves load independently; restore overrides
    always_comb begin
        flags_next = Flags;
        if (flag_write[1]) begin
            flags_next[FLAG_N] = ALUFlag[FLAG_N];
            flags_next[FLAG_Z] = ALUFlag[FLAG_Z];
        end
        if (flag_write[0]) begin
            flags_next[FLAG_C] = ALUFlag[FLAG_C];
            flags_next[FLAG_V] = ALUFlag[FLAG_V];
        end
`ifdef COND_UNIT_SHADOW_EN
        // Save captures the pre-edge flags, so save+restore is a swap
        shadow_next = shadow;
        if (SaveFlags) begin
            shadow_next = Flags;
        end
        if (RestoreFlags) begin
            flags_next = shadow;
        end
`endif
    end

    // Flag register (and shadow) with synchronous reset and stall hold
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            Flags  <= RESET_FLAGS;
`ifdef COND_UNIT_SHADOW_EN
            shadow <= RESET_FLAGS;
`endif
        end else if (!Stall) begin
            Flags  <= flags_next;
`ifdef COND_UNIT_SHADOW_EN
            shadow <= shadow_next;
`endif
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios plus randomized
// traffic checked against a flag-level reference model.
module tb_cond_unit;
    import cpu_pkg::*;

    localparam logic [3:0] RST_VAL = 4'b0000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] Cond;
    logic [3:0] ALUFlag;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, Stall;
`ifdef COND_UNIT_SHADOW_EN
    logic       SaveFlags, RestoreFlags;
`endif
    logic       CondEx, PCSrc, RegWrite, MemWrite;
    flags_t     Flags;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [3:0] m_flags;
    logic [3:0] m_shadow;

    always #5 clk = ~clk;

    cond_unit #(.RESET_FLAGS(RST_VAL)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .Cond         (Cond),
        .ALUFlag      (ALUFlag),
        .FlagW        (FlagW),
        .PCS          (PCS),
        .RegW         (RegW),
        .MemW         (MemW),
        .Stall        (Stall),
`ifdef COND_UNIT_SHADOW_EN
        .SaveFlags    (SaveFlags),
        .RestoreFlags (RestoreFlags),
`endif
        .CondEx       (CondEx),
        .PCSrc        (PCSrc),
        .RegWrite     (RegWrite),
        .MemWrite     (MemWrite),
        .Flags        (Flags)
    );

    // Architectural meaning of each condition mnemonic
    function automatic logic exp_cond(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return z || !c;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle_inputs();
        reset_n = 1'b1; Cond = 4'hE; ALUFlag = 4'h0; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; Stall = 1'b0;
`ifdef COND_UNIT_SHADOW_EN
        SaveFlags = 1'b0; RestoreFlags = 1'b0;
`endif
    endtask

    // Advance one edge, updating the model from the inputs in force before it
    task automatic tick();
        logic [3:0] nf, ns;
        logic ok;
        nf = m_flags; ns = m_shadow;
        if (!reset_n) begin
            nf = RST_VAL; ns = RST_VAL;
        end else if (!Stall) begin
            ok = exp_cond(Cond, m_flags);
            if (ok && FlagW[1]) nf[3:2] = ALUFlag[3:2];
            if (ok && FlagW[0]) nf[1:0] = ALUFlag[1:0];
`ifdef COND_UNIT_SHADOW_EN
            if (RestoreFlags) nf = m_shadow;
            if (SaveFlags)    ns = m_flags;
`endif
        end
        @(posedge clk);
        #1;
        m_flags = nf; m_shadow = ns;
    endtask

    task automatic load_flags(input logic [3:0] f);
        idle_inputs();
        Cond = 4'hE; FlagW = 2'b11; ALUFlag = f;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0; FlagW = 2'b11; ALUFlag = 4'hF;
        tick();
        total++;
        if (Flags !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", Flags); end
        idle_inputs();
        // Reset during a write: write is lost
        load_flags(4'hF);
        reset_n = 1'b0; Cond = 4'hE; FlagW = 2'b11; ALUFlag = 4'hA;
        tick();
        total++;
        if (Flags !== 4'b0000) begin bad++; $display("FAIL reset_wins got=%b exp=0000", Flags); end
        idle_inputs();
        Cond = 4'h0; #1;
        total++;
        if (CondEx !== 1'b0) begin bad++; $display("FAIL reset_eq got=%b exp=0", CondEx); end
        Cond = 4'h1; PCS = 1'b1; #1;
        total++;
        if (CondEx !== 1'b1 || PCSrc !== 1'b1) begin
            bad++; $display("FAIL reset_ne got=%b/%b exp=1/1", CondEx, PCSrc);
        end
        idle_inputs();
    endtask

    task automatic test_halves();
        load_flags(4'b0110);
        total++;
        if (Flags !== 4'b0110) begin bad++; $display("FAIL halves_both got=%b exp=0110", Flags); end
        Cond = 4'hE; FlagW = 2'b10; ALUFlag = 4'b1000;
        tick();
        total++;
        if (Flags !== 4'b1010) begin bad++; $display("FAIL halves_nz_only got=%b exp=1010", Flags); end
        Cond = 4'hE; FlagW = 2'b01; ALUFlag = 4'b1101;
        tick();
        total++;
        if (Flags !== 4'b1001) begin bad++; $display("FAIL halves_cv_only got=%b exp=1001", Flags); end
        idle_inputs();
    endtask

    task automatic test_failed_cond();
        load_flags(4'b0100);
        Cond = 4'h1; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; FlagW = 2'b11; ALUFlag = 4'b1001;
        #1;
        total++;
        if ({CondEx, PCSrc, RegWrite, MemWrite} !== 4'b0000) begin
            bad++; $display("FAIL failed_gating got=%b exp=0000", {CondEx, PCSrc, RegWrite, MemWrite});
        end
        tick();
        total++;
        if (Flags !== 4'b0100) begin bad++; $display("FAIL failed_no_update got=%b exp=0100", Flags); end
        idle_inputs();
    endtask

    task automatic test_signed();
        logic [3:0] got;
        load_flags(4'b1001);
        Cond = 4'hA; #1; got[3] = CondEx;
        Cond = 4'hB; #1; got[2] = CondEx;
        Cond = 4'hC; #1; got[1] = CondEx;
        Cond = 4'hD; #1; got[0] = CondEx;
        total++;
        if (got !== 4'b1010) begin bad++; $display("FAIL signed_nv11 ge/lt/gt/le got=%b exp=1010", got); end
        load_flags(4'b1000);
        Cond = 4'hA; #1; got[3] = CondEx;
        Cond = 4'hB; #1; got[2] = CondEx;
        Cond = 4'hC; #1; got[1] = CondEx;
        Cond = 4'hD; #1; got[0] = CondEx;
        total++;
        if (got !== 4'b0101) begin bad++; $display("FAIL signed_n1v0 ge/lt/gt/le got=%b exp=0101", got); end
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            Cond = 4'hF; RegW = 1'b1; #1;
            total++;
            if (CondEx !== 1'b0 || RegWrite !== 1'b0) begin
                bad++; $display("FAIL nv_flags=%b got=%b/%b exp=0/0", 4'(f), CondEx, RegWrite);
            end
        end
        idle_inputs();
    endtask

    task automatic test_stall();
        load_flags(4'b0101);
        Stall = 1'b1; Cond = 4'hE; FlagW = 2'b11; ALUFlag = 4'hF;
        tick();
        total++;
        if (Flags !== 4'b0101) begin bad++; $display("FAIL stall_hold got=%b exp=0101", Flags); end
        Stall = 1'b0;
        tick();
        total++;
        if (Flags !== 4'b1111) begin bad++; $display("FAIL stall_release got=%b exp=1111", Flags); end
        idle_inputs();
    endtask

`ifdef COND_UNIT_SHADOW_EN
    task automatic test_shadow();
        load_flags(4'b0011);
        SaveFlags = 1'b1; Cond = 4'hE; FlagW = 2'b11; ALUFlag = 4'b1100;
        tick();
        total++;
        if (Flags !== 4'b1100) begin bad++; $display("FAIL shadow_save_write got=%b exp=1100", Flags); end
        idle_inputs();
        RestoreFlags = 1'b1; Cond = 4'hE; FlagW = 2'b11; ALUFlag = 4'b0000;
        tick();
        total++;
        if (Flags !== 4'b0011) begin bad++; $display("FAIL shadow_restore got=%b exp=0011", Flags); end
        idle_inputs();
        load_flags(4'b0110);
        SaveFlags = 1'b1; RestoreFlags = 1'b1;
        tick();
        total++;
        if (Flags !== 4'b0011) begin bad++; $display("FAIL shadow_swap_flags got=%b exp=0011", Flags); end
        idle_inputs();
        RestoreFlags = 1'b1;
        tick();
        total++;
        if (Flags !== 4'b0110) begin bad++; $display("FAIL shadow_swap_shadow got=%b exp=0110", Flags); end
        idle_inputs();
    endtask
`endif

    task automatic test_back_to_back();
        logic [3:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 4'($urandom_range(0, 15));
            Cond = 4'hE; FlagW = 2'b11; ALUFlag = v;
            tick();
            total++;
            if (Flags !== v) begin bad++; $display("FAIL b2b_%0d got=%b exp=%b", i, Flags, v); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic exp_ok;
        for (int i = 0; i < 300; i++) begin
            reset_n = ($urandom_range(0, 39) != 0);
            Stall   = ($urandom_range(0, 5) == 0);
            Cond    = 4'($urandom_range(0, 15));
            ALUFlag = 4'($urandom_range(0, 15));
            FlagW   = 2'($urandom_range(0, 3));
            PCS     = 1'($urandom_range(0, 1));
            RegW    = 1'($urandom_range(0, 1));
            MemW    = 1'($urandom_range(0, 1));
`ifdef COND_UNIT_SHADOW_EN
            SaveFlags    = ($urandom_range(0, 7) == 0);
            RestoreFlags = ($urandom_range(0, 7) == 0);
`endif
            #1;
            exp_ok = exp_cond(Cond, m_flags);
            total++;
            if ({CondEx, PCSrc, RegWrite, MemWrite} !== {exp_ok, PCS & exp_ok, RegW & exp_ok, MemW & exp_ok}) begin
                bad++;
                $display("FAIL rand_comb_%0d cond=%h flags=%b got=%b exp=%b", i, Cond, m_flags,
                         {CondEx, PCSrc, RegWrite, MemWrite},
                         {exp_ok, PCS & exp_ok, RegW & exp_ok, MemW & exp_ok});
            end
            tick();
            total++;
            if (Flags !== m_flags) begin bad++; $display("FAIL rand_flags_%0d got=%b exp=%b", i, Flags, m_flags); end
        end
        idle_inputs();
    endtask

    initial begin
        m_flags = 4'bxxxx;
        m_shadow = 4'bxxxx;
        idle_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_halves();
        test_failed_cond();
        test_signed();
        test_stall();
`ifdef COND_UNIT_SHADOW_EN
        test_shadow();
`endif
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
